// File: rtl/adc_cfg_pkg.sv
// Shared definitions for the ADC/DAC front-end power-up configuration
// sequencer: ROM entry field positions, error codes, FSM state encoding
// and a counter-width helper.
package adc_cfg_pkg;

  // Table entry layout: {verify_en[15], addr[14:8], data[7:0]}
  localparam int ENTRY_W    = 16;
  localparam int VERIFY_BIT = 15;
  localparam int ADDR_MSB   = 14;
  localparam int ADDR_LSB   = 8;
  localparam int DATA_MSB   = 7;
  localparam int DATA_LSB   = 0;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;

  // err_code values
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_VERIFY  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_PWR   = 4'd1,
    ST_FETCH = 4'd2,
    ST_WR    = 4'd3,
    ST_RD    = 4'd4,
    ST_CHK   = 4'd5,
    ST_NEXT  = 4'd6,
    ST_DONE  = 4'd7,
    ST_FAIL  = 4'd8
  } state_t;

  // Bits needed to hold the value max_val (at least 1).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/adc_init_rom.sv
// Board-specific register initialisation table.
// Ports:
//   idx_i   - entry index
//   entry_o - {verify_en, addr[6:0], data[7:0]} for that index
// Indices without an entry return 0 (write 0x00 to address 0, no verify).
module adc_init_rom
  import adc_cfg_pkg::*;
#(
  parameter int NUM_REGS = 16,
  localparam int IDX_W   = $clog2(NUM_REGS) + 1
) (
  input  logic [IDX_W-1:0]   idx_i,
  output logic [ENTRY_W-1:0] entry_o
);

  always_comb begin
    entry_o = '0;
    // Compare as int so short index widths cannot alias case items.
    case (int'(idx_i))
      0:       entry_o = 16'h815A;  // verify, addr 0x01, data 0x5A
      1:       entry_o = 16'h023C;  // addr 0x02, data 0x3C
      2:       entry_o = 16'h8310;  // verify, addr 0x03, data 0x10
      3:       entry_o = 16'h0480;  // addr 0x04, data 0x80
      4:       entry_o = 16'h8507;  // verify, addr 0x05, data 0x07
      default: entry_o = '0;
    endcase
  end

endmodule

// File: rtl/adc_reg_init_seq.sv
// Power-up configuration sequencer for the SPI register-access controller.
// Walks the init ROM and writes each entry, optionally reading it back and
// retrying on mismatch; reports busy/done/error.
// Ports:
//   clk, rst            - clock, async active-high reset
//   start               - begin a sequence (honoured in IDLE only)
//   busy/done/error     - status; done/error sticky until next start
//   err_addr/err_code   - failing address, 0 none/1 verify/2 timeout
//   cmd_write, write_*  - write request + address/data, ack cmd_write_ack
//   cmd_read, read_addr - read request + address, ack cmd_read_ack
//   read_data           - readback, valid in the cmd_read_ack cycle
//   dbg_state           - current FSM state
//
// Handshake: a request (cmd_write/cmd_read) is registered, stays high with
// its address/data frozen until the controller returns a one-cycle ack, and
// is low in the cycle after the ack. The two requests are never high
// together. A request with no ack within TIMEOUT cycles is dropped.
module adc_reg_init_seq
  import adc_cfg_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int PWR_WAIT   = 50000,  // must be >= 1
  parameter int MAX_RETRY  = 3,
  parameter int TIMEOUT    = 4096,   // must be >= 1
  parameter bit AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [1:0]        err_code,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic              cmd_write_ack,
  output logic              cmd_read,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  input  logic              cmd_read_ack,
  output state_t            dbg_state
);

  localparam int IDX_W  = $clog2(NUM_REGS) + 1;
  localparam int WAIT_W = cnt_w(PWR_WAIT);
  localparam int TMO_W  = cnt_w(TIMEOUT);
  localparam int RTY_W  = cnt_w(MAX_RETRY);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [RTY_W-1:0]    retry_q, retry_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [ENTRY_W-1:0]  entry_q, entry_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                auto_q, auto_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                cmd_write_q, cmd_write_d;
  logic                cmd_read_q, cmd_read_d;

  logic [ENTRY_W-1:0]  rom_entry;
  logic [ADDR_W-1:0]   entry_addr;
  logic [DATA_W-1:0]   entry_data;
  logic                tmo_hit;

  adc_init_rom #(.NUM_REGS(NUM_REGS)) u_rom (
    .idx_i   (idx_q),
    .entry_o (rom_entry)
  );

  assign entry_addr = entry_q[ADDR_MSB:ADDR_LSB];
  assign entry_data = entry_q[DATA_MSB:DATA_LSB];
  // Last request cycle before the budget runs out.
  assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      wait_q      <= '0;
      tmo_q       <= '0;
      entry_q     <= '0;
      rdata_q     <= '0;
      auto_q      <= AUTO_START;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_addr_q  <= '0;
      err_code_q  <= ERR_NONE;
      cmd_write_q <= 1'b0;
      cmd_read_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      wait_q      <= wait_d;
      tmo_q       <= tmo_d;
      entry_q     <= entry_d;
      rdata_q     <= rdata_d;
      auto_q      <= auto_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_addr_q  <= err_addr_d;
      err_code_q  <= err_code_d;
      cmd_write_q <= cmd_write_d;
      cmd_read_q  <= cmd_read_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    wait_d      = wait_q;
    tmo_d       = '0;  // only advances while a request waits for its ack
    entry_d     = entry_q;
    rdata_d     = rdata_q;
    auto_d      = auto_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    err_addr_d  = err_addr_q;
    err_code_d  = err_code_q;
    cmd_write_d = cmd_write_q;
    cmd_read_d  = cmd_read_q;

    case (state_q)
      ST_IDLE: begin
        if (start || auto_q) begin
          auto_d     = 1'b0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          err_addr_d = '0;
          busy_d     = 1'b1;
          idx_d      = '0;
          wait_d     = '0;
          state_d    = ST_PWR;
        end
      end
      ST_PWR: begin
        if (wait_q == WAIT_W'(PWR_WAIT - 1)) begin
          wait_d  = '0;
          state_d = ST_FETCH;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_FETCH: begin
        entry_d     = rom_entry;
        retry_d     = '0;
        cmd_write_d = 1'b1;
        state_d     = ST_WR;
      end
      ST_WR: begin
        if (cmd_write_ack) begin
          cmd_write_d = 1'b0;
          if (entry_q[VERIFY_BIT]) begin
            cmd_read_d = 1'b1;  // write is low in this cycle, so no overlap
            state_d    = ST_RD;
          end else begin
            state_d = ST_NEXT;
          end
        end else if (tmo_hit) begin
          cmd_write_d = 1'b0;
          err_code_d  = ERR_TIMEOUT;
          err_addr_d  = entry_addr;
          state_d     = ST_FAIL;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RD: begin
        if (cmd_read_ack) begin
          rdata_d    = read_data;
          cmd_read_d = 1'b0;
          state_d    = ST_CHK;
        end else if (tmo_hit) begin
          cmd_read_d = 1'b0;
          err_code_d = ERR_TIMEOUT;
          err_addr_d = entry_addr;
          state_d    = ST_FAIL;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_CHK: begin
        if (rdata_q == entry_data) begin
          state_d = ST_NEXT;
        end else if (retry_q < RTY_W'(MAX_RETRY)) begin
          retry_d     = retry_q + 1'b1;
          cmd_write_d = 1'b1;
          state_d     = ST_WR;
        end else begin
          err_code_d = ERR_VERIFY;
          err_addr_d = entry_addr;
          state_d    = ST_FAIL;
        end
      end
      ST_NEXT: begin
        if (idx_q == IDX_W'(NUM_REGS - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_FAIL: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_addr   = err_addr_q;
  assign err_code   = err_code_q;
  assign cmd_write  = cmd_write_q;
  assign write_addr = entry_addr;
  assign write_data = entry_data;
  assign cmd_read   = cmd_read_q;
  assign read_addr  = entry_addr;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_adc_reg_init_seq.sv
// Bench for adc_reg_init_seq: SPI controller model, command-trace scoreboard
// and directed scenarios (normal run, verify exhaustion, single retry, ack
// timeout, stray start/ack, reset mid-read with auto restart).
module tb_adc_reg_init_seq;
  import adc_cfg_pkg::*;

  localparam int NUM_REGS   = 2;
  localparam int PWR_WAIT   = 10;
  localparam int MAX_RETRY  = 3;
  localparam int TB_TIMEOUT = 400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        busy, done, error;
  logic [6:0]  err_addr;
  logic [1:0]  err_code;
  logic        cmd_write, cmd_read;
  logic [6:0]  write_addr, read_addr;
  logic [7:0]  write_data;
  logic        cmd_write_ack = 1'b0;
  logic        cmd_read_ack  = 1'b0;
  logic [7:0]  read_data     = 8'h00;
  state_t      dbg_state;

  adc_reg_init_seq #(
    .NUM_REGS   (NUM_REGS),
    .PWR_WAIT   (PWR_WAIT),
    .MAX_RETRY  (MAX_RETRY),
    .TIMEOUT    (TB_TIMEOUT),
    .AUTO_START (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_addr      (err_addr),
    .err_code      (err_code),
    .cmd_write     (cmd_write),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .cmd_write_ack (cmd_write_ack),
    .cmd_read      (cmd_read),
    .read_addr     (read_addr),
    .read_data     (read_data),
    .cmd_read_ack  (cmd_read_ack),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  // Command record: {kind[1:0] (1 write, 2 read), addr[6:0], data[7:0]}
  logic [16:0] exp_q[$];
  int n_vec   = 0;
  int n_err   = 0;
  int cmd_cnt = 0;

  // SPI model controls
  logic [7:0] mem [0:127];
  bit ack_en    = 1'b1;
  int ack_delay = 3;
  int bad_reads = 0;
  bit stray_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_wr(input logic [6:0] a, input logic [7:0] d);
    exp_q.push_back({2'd1, a, d});
  endtask

  task automatic exp_rd(input logic [6:0] a);
    exp_q.push_back({2'd2, a, 8'h00});
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input int max_cyc);
    int n = 0;
    while (!(!busy && (done || error)) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL end_wait: no done/error within %0d cycles", max_cyc);
    end
  endtask

  task automatic wait_sig_read(input int max_cyc);
    int n = 0;
    while (!cmd_read && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("read_seen", 32'(cmd_read), 32'd1);
  endtask

  // SPI controller model: acks a request ack_delay cycles after it is seen,
  // stores writes and returns stored data (or 0xFF while bad_reads > 0).
  task automatic model_loop();
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (cmd_write_ack || cmd_read_ack) begin
        cmd_write_ack = 1'b0;
        cmd_read_ack  = 1'b0;
        cnt = 0;
      end else if (stray_req) begin
        cmd_write_ack = 1'b1;
        cmd_read_ack  = 1'b1;
        stray_req = 1'b0;
      end else if (rst || !(cmd_write || cmd_read)) begin
        cnt = 0;
      end else if (ack_en) begin
        cnt++;
        if (cnt >= ack_delay) begin
          if (cmd_write) begin
            mem[write_addr] = write_data;
            cmd_write_ack = 1'b1;
          end else begin
            if (read_addr == 7'h01 && bad_reads > 0) begin
              read_data = 8'hFF;
              bad_reads--;
            end else begin
              read_data = mem[read_addr];
            end
            cmd_read_ack = 1'b1;
          end
        end
      end
    end
  endtask

  // Monitor: pops the expected trace on every new request and checks
  // request exclusivity and stability while held.
  task automatic monitor_loop();
    logic pw = 1'b0, pr = 1'b0;
    logic [6:0] ha = '0;
    logic [7:0] hd = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        pw = 1'b0;
        pr = 1'b0;
      end else begin
        if (cmd_write || cmd_read)
          check("req_exclusive", 32'(cmd_write & cmd_read), 32'd0);
        if ((cmd_write && !pw) || (cmd_read && !pr)) begin
          cmd_cnt++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL cmd_unexpected: got w=%0d r=%0d addr 0x%0h, expected none",
                     cmd_write, cmd_read, cmd_write ? write_addr : read_addr);
          end else if (cmd_write) begin
            check("cmd_trace", 32'({2'd1, write_addr, write_data}), 32'(exp_q.pop_front()));
          end else begin
            check("cmd_trace", 32'({2'd2, read_addr, 8'h00}), 32'(exp_q.pop_front()));
          end
          ha = cmd_write ? write_addr : read_addr;
          hd = write_data;
        end else if (cmd_write) begin
          check("wr_stable", 32'({write_addr, write_data}), 32'({ha, hd}));
        end else if (cmd_read) begin
          check("rd_stable", 32'(read_addr), 32'(ha));
        end
        pw = cmd_write;
        pr = cmd_read;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int base;
    int n;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    fork
      model_loop();
      monitor_loop();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_status", 32'({busy, done, error, err_addr, err_code}), 32'd0);
    check("rst_cmd", 32'({cmd_write, write_addr, write_data, cmd_read, read_addr}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // 1: auto start, slow controller, good readback
    ack_delay = 300;
    base = cmd_cnt;
    exp_wr(7'h01, 8'h5A); exp_rd(7'h01); exp_wr(7'h02, 8'h3C);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("auto_busy", 32'(busy), 32'd1);
    wait_end(3000);
    check("t1_status", 32'({busy, done, error, err_code}), 32'({1'b0, 1'b1, 1'b0, ERR_NONE}));
    check("t1_cmds", 32'(cmd_cnt - base), 32'd3);
    check("t1_queue", 32'(exp_q.size()), 32'd0);

    // 2: readback always wrong -> 4 write/read pairs then verify error
    ack_delay = 3;
    bad_reads = 1000;
    base = cmd_cnt;
    for (int i = 0; i < 4; i++) begin exp_wr(7'h01, 8'h5A); exp_rd(7'h01); end
    pulse_start();
    wait_end(2000);
    check("t2_status", 32'({busy, done, error}), 32'({1'b0, 1'b0, 1'b1}));
    check("t2_err_code", 32'(err_code), 32'(ERR_VERIFY));
    check("t2_err_addr", 32'(err_addr), 32'h01);
    check("t2_cmds", 32'(cmd_cnt - base), 32'd8);
    check("t2_queue", 32'(exp_q.size()), 32'd0);

    // 3: one wrong readback then correct -> one retry, done
    bad_reads = 1;
    base = cmd_cnt;
    exp_wr(7'h01, 8'h5A); exp_rd(7'h01); exp_wr(7'h01, 8'h5A); exp_rd(7'h01);
    exp_wr(7'h02, 8'h3C);
    pulse_start();
    wait_end(2000);
    check("t3_status", 32'({busy, done, error, err_code}), 32'({1'b0, 1'b1, 1'b0, ERR_NONE}));
    check("t3_cmds", 32'(cmd_cnt - base), 32'd5);
    check("t3_queue", 32'(exp_q.size()), 32'd0);

    // 4: controller never acks -> write held TIMEOUT cycles, timeout error
    bad_reads = 0;
    ack_en = 1'b0;
    exp_wr(7'h01, 8'h5A);
    pulse_start();
    n = 0;
    while (!cmd_write && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (cmd_write && n < 1000) begin n++; @(negedge clk); end
    check("t4_wr_len", 32'(n), 32'(TB_TIMEOUT));
    wait_end(100);
    check("t4_status", 32'({busy, done, error}), 32'({1'b0, 1'b0, 1'b1}));
    check("t4_err_code", 32'(err_code), 32'(ERR_TIMEOUT));
    check("t4_err_addr", 32'(err_addr), 32'h01);
    ack_en = 1'b1;

    // 5: stray acks while idle, then a start pulse mid-sequence
    base = cmd_cnt;
    @(negedge clk); stray_req = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_idle_cmds", 32'(cmd_cnt - base), 32'd0);
    check("t5_idle_busy", 32'(busy), 32'd0);
    exp_wr(7'h01, 8'h5A); exp_rd(7'h01); exp_wr(7'h02, 8'h3C);
    pulse_start();
    wait_sig_read(100);
    check("t5_busy_mid", 32'(busy), 32'd1);
    pulse_start();
    wait_end(2000);
    repeat (30) @(negedge clk);
    check("t5_status", 32'({busy, done, error}), 32'({1'b0, 1'b1, 1'b0}));
    check("t5_cmds", 32'(cmd_cnt - base), 32'd3);
    check("t5_queue", 32'(exp_q.size()), 32'd0);

    // 6: reset during the read, then automatic restart after PWR_WAIT
    ack_delay = 20;
    exp_wr(7'h01, 8'h5A); exp_rd(7'h01);
    pulse_start();
    wait_sig_read(100);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_status", 32'({busy, done, error, err_addr, err_code}), 32'd0);
    check("t6_rst_cmd", 32'({cmd_write, write_addr, write_data, cmd_read, read_addr}), 32'd0);
    check("t6_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("t6_queue_pre", 32'(exp_q.size()), 32'd0);
    ack_delay = 3;
    exp_wr(7'h01, 8'h5A); exp_rd(7'h01); exp_wr(7'h02, 8'h3C);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_write && n < 100);
    check("t6_restart_lat", 32'(n), 32'(PWR_WAIT + 2));
    wait_end(2000);
    check("t6_status", 32'({busy, done, error}), 32'({1'b0, 1'b1, 1'b0}));
    check("t6_queue", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
